sm_uart_cmd_rx: RTL and testbench

Serial command receiver for the soil-monitoring bot, the counterpart of the status transmitter on `tx`. It accepts 8N1 bytes on `rx` from the host radio link and parses fixed four-byte ASCII command frames. For each valid frame it emits a one-cycle command strobe with a command code and target node number for the path/ADC control logic. The block sits beside the UART transmitter at top level and shares its `clk_50M` domain.

---
 rtl/sm_uart_pkg.sv | 57 +++++
 rtl/sm_uart_rx_byte.sv | 96 +++++++++
 rtl/sm_uart_cmd_rx.sv | 105 ++++++++++
 tb/tb_sm_uart_cmd_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sm_uart_pkg.sv
// rtl/sm_uart_pkg.sv - shared constants, state encodings and helpers for the UART command receiver
package sm_uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;

  localparam logic [7:0] ASCII_N    = 8'h4E;
  localparam logic [7:0] ASCII_P    = 8'h50;
  localparam logic [7:0] ASCII_D    = 8'h44;
  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;

  typedef enum logic [1:0] {
    CMD_NODE = 2'b00,
    CMD_PICK = 2'b01,
    CMD_DEPO = 2'b10
  } cmd_code_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_D1,
    P_D2,
    P_END
  } parse_state_e;

  function automatic logic is_cmd_char(input logic [7:0] b);
    return (b == ASCII_N) || (b == ASCII_P) || (b == ASCII_D);
  endfunction

  function automatic cmd_code_e cmd_of_char(input logic [7:0] b);
    case (b)
      ASCII_P: return CMD_PICK;
      ASCII_D: return CMD_DEPO;
      default: return CMD_NODE;
    endcase
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  // tens*10 + units as shift-and-add; 99 fits in 7 bits
  function automatic logic [6:0] node_of(input logic [3:0] d1, input logic [3:0] d2);
    logic [6:0] t;
    t = {3'b000, d1};
    return (t << 3) + (t << 1) + {3'b000, d2};
  endfunction

endpackage

// File: rtl/sm_uart_rx_byte.sv
// rtl/sm_uart_rx_byte.sv - rx synchroniser and 8N1 byte receiver with framing-error detection
module sm_uart_rx_byte
  import sm_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic            rx_meta;
  logic            rx_sync;
  rx_state_e       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_sync) state <= IDLE == IDLE ? START : IDLE;
        end
        // mid-start-bit recheck rejects short low glitches
        START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            state <= rx_sync ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_sync) begin
              byte_data  <= shreg;
              byte_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sm_uart_cmd_rx.sv
// rtl/sm_uart_cmd_rx.sv - parses four-byte ASCII command frames (cmd, tens, units, '#') from the UART
module sm_uart_cmd_rx
  import sm_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic [6:0] cmd_node,
  output logic       err
);

  logic         frame_err;
  parse_state_e p_state;
  cmd_code_e    code_q;
  logic [3:0]   d1_q;
  logic [3:0]   d2_q;
  logic         byte_is_cmd;
  cmd_code_e    byte_cmd;
  logic         bad_byte;

  sm_uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign byte_is_cmd = is_cmd_char(byte_data);
  assign byte_cmd    = cmd_of_char(byte_data);

  always_comb begin
    bad_byte = 1'b0;
    case (p_state)
      P_D1, P_D2: bad_byte = !is_digit(byte_data);
      P_END:      bad_byte = (byte_data != ASCII_HASH);
      default:    bad_byte = 1'b0;
    endcase
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      p_state   <= P_IDLE;
      code_q    <= CMD_NODE;
      d1_q      <= '0;
      d2_q      <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_node  <= '0;
      err       <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      err       <= 1'b0;
      if (frame_err) begin
        err     <= 1'b1;
        p_state <= P_IDLE;
      end else if (byte_valid) begin
        // a misplaced command char starts a fresh frame instead of being lost
        if (bad_byte) begin
          err <= 1'b1;
          if (byte_is_cmd) begin
            code_q  <= byte_cmd;
            p_state <= P_D1;
          end else begin
            p_state <= P_IDLE;
          end
        end else begin
          case (p_state)
            P_IDLE: begin
              if (byte_is_cmd) begin
                code_q  <= byte_cmd;
                p_state <= P_D1;
              end
            end
            P_D1: begin
              d1_q    <= byte_data[3:0];
              p_state <= P_D2;
            end
            P_D2: begin
              d2_q    <= byte_data[3:0];
              p_state <= P_END;
            end
            P_END: begin
              cmd_code  <= code_q;
              cmd_node  <= node_of(d1_q, d2_q);
              cmd_valid <= 1'b1;
              p_state   <= P_IDLE;
            end
            default: p_state <= P_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sm_uart_cmd_rx.sv
// tb/tb_sm_uart_cmd_rx.sv - scoreboard bench for sm_uart_cmd_rx with a frame-level reference model
module tb_sm_uart_cmd_rx;

  localparam int CPB = 40;

  logic       clk_50M = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic [6:0] cmd_node;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_byte_q[$];
  logic [8:0] exp_cmd_q[$];
  int         exp_err_q[$];
  logic [7:0] frame_q[$];

  always #10 clk_50M = ~clk_50M;

  sm_uart_cmd_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_node   (cmd_node),
    .err        (err)
  );

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic bit m_is_cmd(input logic [7:0] b);
    return b == 8'h4E || b == 8'h50 || b == 8'h44;
  endfunction

  function automatic int m_code(input logic [7:0] b);
    if (b == 8'h4E) return 0;
    if (b == 8'h50) return 1;
    return 2;
  endfunction

  // Reference: collect frame chars in a queue; on completion emit (code, tens*10+units)
  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    bit ok;
    int node;
    if (!stop_ok) begin
      exp_err_q.push_back(1);
      frame_q.delete();
      return;
    end
    exp_byte_q.push_back(b);
    if (frame_q.size() == 0) begin
      if (m_is_cmd(b)) frame_q.push_back(b);
    end else begin
      if (frame_q.size() < 3) ok = (b >= 8'h30 && b <= 8'h39);
      else ok = (b == 8'h23);
      if (ok && frame_q.size() == 3) begin
        node = (int'(frame_q[1]) - 48) * 10 + (int'(frame_q[2]) - 48);
        exp_cmd_q.push_back({2'(m_code(frame_q[0])), 7'(node)});
        frame_q.delete();
      end else if (ok) begin
        frame_q.push_back(b);
      end else begin
        exp_err_q.push_back(1);
        frame_q.delete();
        if (m_is_cmd(b)) frame_q.push_back(b);
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_bit);
    model_byte(b, stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk_50M);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk_50M);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk_50M);
    if (!stop_bit) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk_50M);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_data"}, byte_data, 0);
    check({tag, "_byte_valid"}, byte_valid, 0);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_cmd_code"}, cmd_code, 0);
    check({tag, "_cmd_node"}, cmd_node, 0);
    check({tag, "_err"}, err, 0);
  endtask

  always @(negedge clk_50M) begin
    if (!rst) begin
      if (byte_valid) begin
        if (exp_byte_q.size() == 0) check("unexpected_byte_valid", byte_data, -1);
        else check("byte_data", byte_data, exp_byte_q.pop_front());
      end
      if (cmd_valid) begin
        check("cmd_byte_overlap", byte_valid, 0);
        if (exp_cmd_q.size() == 0) check("unexpected_cmd_valid", {cmd_code, cmd_node}, -1);
        else check("cmd_code_node", {cmd_code, cmd_node}, exp_cmd_q.pop_front());
      end
      if (err) begin
        if (exp_err_q.size() == 0) check("unexpected_err", 1, 0);
        else check("err_pulse", 1, exp_err_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] fr[4];
    logic [7:0] rb;
    int mode;

    repeat (5) @(negedge clk_50M);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(5);

    send_str("N07#");
    idle(CPB);
    send_str("P42#D99#");
    idle(CPB);

    // short low pulse well under half a bit must be dropped as a glitch
    rx = 1'b0;
    repeat (12) @(negedge clk_50M);
    idle(3 * CPB);

    send_byte(8'h55, 1'b0);
    idle(CPB);
    send_str("N03#");
    idle(CPB);

    send_str("N7#");
    send_str("NN12#");
    idle(CPB);

    send_byte(8'h50, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk_50M);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      repeat (CPB) @(negedge clk_50M);
    end
    rst = 1'b1;
    rx = 1'b1;
    frame_q.delete();
    repeat (3) @(negedge clk_50M);
    check_reset_outputs("midreset");
    rst = 1'b0;
    idle(CPB);
    send_str("P05#");
    idle(CPB);

    for (int k = 0; k < 14; k++) begin
      mode = $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0:       fr[0] = 8'h4E;
        1:       fr[0] = 8'h50;
        default: fr[0] = 8'h44;
      endcase
      fr[1] = 8'(8'h30 + $urandom_range(0, 9));
      fr[2] = 8'(8'h30 + $urandom_range(0, 9));
      fr[3] = 8'h23;
      if (mode == 1) fr[$urandom_range(0, 3)] = 8'($urandom_range(0, 255));
      if (mode == 2) begin
        for (int j = 0; j < 3; j++) send_byte(8'($urandom_range(0, 255)), 1'b1);
      end else if (mode == 3) begin
        send_byte(fr[0], 1'b1);
        rb = 8'($urandom_range(0, 255));
        send_byte(rb, 1'b0);
        idle($urandom_range(1, 5));
        for (int j = 0; j < 4; j++) send_byte(fr[j], 1'b1);
      end else begin
        for (int j = 0; j < 4; j++) send_byte(fr[j], 1'b1);
      end
      idle($urandom_range(0, 5));
    end

    idle(4 * CPB);
    check("pending_bytes", exp_byte_q.size(), 0);
    check("pending_cmds", exp_cmd_q.size(), 0);
    check("pending_errs", exp_err_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
